// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: 2-entry in-order result buffer between the ALU and the
// architectural state. It retires into a 16x32 register file and the NZVC
// flag register, and its two combinational read ports forward from buffered
// entries that have not retired yet.
module alu_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wr_en,
  input  logic              in_flag_en,
  input  logic              wb_hold,
  input  logic [REG_AW-1:0] rs_a_addr,
  output logic [DATA_W-1:0] rs_a_data,
  input  logic [REG_AW-1:0] rs_b_addr,
  output logic [DATA_W-1:0] rs_b_data,
  output logic [FLAG_W-1:0] flags_nzvc,
  output logic              retire_valid,
  output logic [REG_AW-1:0] retire_rd,
  output logic [1:0]        buf_count
);

  localparam int         NREG = 1 << REG_AW;
  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [FLAG_W-1:0] flags;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              flag_en;
  } entry_t;

  // ent[0] is always the head; ent[1] is the younger entry when count == 2
  entry_t            ent [DEPTH];
  entry_t            in_ent;
  logic [1:0]        count;
  logic              push, pop;
  logic [DATA_W-1:0] rf  [NREG];

  assign in_ent    = '{result: in_result, flags: in_flags, rd: in_rd,
                       wr_en: in_wr_en, flag_en: in_flag_en};
  // ready depends on state only, and stays low while reset is asserted
  assign in_ready  = reset_n && (count < FULL);
  assign push      = in_valid && in_ready;
  assign pop       = (count != 2'd0) && !wb_hold;
  assign buf_count = count;

  // Buffer shift/insert: pop shifts the younger entry down to the head;
  // a push lands in the first slot that is free after this edge's pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent[0] <= '0;
      ent[1] <= '0;
      count  <= 2'd0;
    end else begin
      if (pop) ent[0] <= ent[1];
      if (push) begin
        if (count == 2'd0 || pop) ent[0] <= in_ent;
        else                      ent[1] <= in_ent;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Retirement of the head into architectural state; r0 writes are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      flags_nzvc   <= '0;
      retire_valid <= 1'b0;
      retire_rd    <= '0;
    end else begin
      retire_valid <= pop;
      if (pop) begin
        retire_rd <= ent[0].rd;
        if (ent[0].wr_en && ent[0].rd != '0) rf[ent[0].rd] <= ent[0].result;
        if (ent[0].flag_en)                   flags_nzvc    <= ent[0].flags;
      end
    end
  end

  logic [1:0][REG_AW-1:0] rs_addr;
  logic [1:0][DATA_W-1:0] rs_data;

  assign rs_addr   = {rs_b_addr, rs_a_addr};
  assign rs_a_data = rs_data[0];
  assign rs_b_data = rs_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] d;
    // Read port: younger matching entry overrides older, which overrides rf
    always_comb begin
      d = rf[rs_addr[p]];
      if (count != 2'd0 && ent[0].wr_en && ent[0].rd == rs_addr[p]) d = ent[0].result;
      if (count == 2'd2 && ent[1].wr_en && ent[1].rd == rs_addr[p]) d = ent[1].result;
      if (rs_addr[p] == '0) d = '0;
    end
    assign rs_data[p] = d;
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
Downstream neighbour of the ALU. It accepts each ALU result (32-bit R1 plus NZVC flags) with a destination register index through a valid/ready handshake, and holds results in a 2-entry in-order buffer. It retires them into a 16x32 architectural register file and the NZVC flag register. It also provides the two combinational read ports that source the ALU's R2/R3 operands, with forwarding from not-yet-retired buffer entries.

Parameters:
DATA_W, 32, datapath width (must match ALU R1 width)
REG_AW, 4, register index width; register file depth = 2**REG_AW
FLAG_W, 4, flag width, ordered n,z,v,c from MSB to LSB
DEPTH, 2, buffer entries; fixed at 2, other values unsupported

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  ALU result valid
in_ready  out  1  stage can accept a result this cycle
in_result  in  DATA_W  ALU R1 value
in_flags  in  FLAG_W  ALU flags_n_z_v_c
in_rd  in  REG_AW  destination register index
in_wr_en  in  1  result writes the register file (0 for compare-only SUB)
in_flag_en  in  1  result updates the flag register
wb_hold  in  1  stall retirement this cycle
rs_a_addr  in  REG_AW  read port A index (feeds ALU R2)
rs_a_data  out  DATA_W  read port A data
rs_b_addr  in  REG_AW  read port B index (feeds ALU R3)
rs_b_data  out  DATA_W  read port B data
flags_nzvc  out  FLAG_W  architectural flag register
retire_valid  out  1  one-cycle pulse: an entry retired on this edge
retire_rd  out  REG_AW  index of the entry retired (valid with retire_valid)
buf_count  out  2  occupied entries, 0..2

Behaviour:
- Reset (reset_n low, asynchronous): all registers = 0, flags_nzvc = 0, buffer empty, buf_count = 0, retire_valid = 0, retire_rd = 0, in_ready = 0. Reset mid-operation discards all buffered entries with no retirement.
- in_ready = reset_n && (buf_count < 2). It depends only on state, never on in_valid.
- Accept: when in_valid && in_ready at a rising edge, the entry (result, flags, rd, wr_en, flag_en) is pushed at the tail.
- Retire: when buf_count > 0 && !wb_hold at a rising edge, the head entry pops.
  - If wr_en && rd != 0: regfile[rd] <= result.
  - If flag_en: flags_nzvc <= flags.
  - retire_valid and retire_rd are registered: high the cycle after that edge.
- Strict in-order retirement, one entry per cycle maximum.
- Minimum latency: accepted at edge N, retired at edge N+1 (if no hold), visible in regfile/flags after edge N+1.
- Simultaneous accept and retire at buf_count 1: count stays 1, and the new entry becomes head. This cannot occur at count 2 because in_ready = 0.
- At count 0, an accepted entry is never retired on the same edge.
- wb_hold held indefinitely: buffer fills to 2, in_ready drops, and the buffer contents and flags are frozen.
- Register 0 reads as 0 always; writes to it are discarded, but its flag update still applies.
- Read ports (combinational, both identical):
  - addr == 0 -> 0.
  - Otherwise the youngest buffered entry with wr_en && rd == addr supplies the data.
  - Otherwise regfile[addr].
  - Entries accepted this same cycle are not forwarded (not yet in buffer).
- flags_nzvc is architectural only, never forwarded.

Test Plan:
1. Reset, then single accept of result 0x0000_0005, rd 3, wr_en 1, flag_en 1, flags 4'b0000, no hold -> in_ready 1. Next cycle retire_valid 1 and retire_rd 3; after that, rs_a_addr 3 reads 0x5.
2. wb_hold 1, accept rd 2 = 0x11, then rd 2 = 0x22 -> buf_count 2, in_ready 0, rs_b_addr 2 reads 0x22 (youngest forwarded). Release hold -> two retire pulses in order, final regfile[2] = 0x22.
3. Accept rd 0, result 0xFFFF_FFFF, flags 4'b1000, flag_en 1 -> rs_a_addr 0 reads 0, and flags_nzvc = 4'b1000 after retire.
4. Compare-only SUB: wr_en 0, flag_en 1, flags 4'b0100, rd 5 with prior regfile[5] = 0x7 -> regfile[5] stays 0x7 (no forwarding of the entry), and flags_nzvc = 4'b0100.
5. Streaming: in_valid high 8 cycles with results 1..8 to rd 1..8, no hold -> in_ready stays 1, buf_count ≤ 1, one retire per cycle, and each register n holds n.
6. Fill buffer under hold, assert reset_n low mid-cycle -> outputs and buf_count go 0 immediately, with no retire_valid pulse and flags_nzvc = 0.
